// File: rtl/psum_accumulator_if.sv
// Streaming handshakes around the partial-sum accumulator: psum words in, ofmap words out.
interface psum_accumulator_if #(
    parameter int DATA_W = 16
);
    logic                     psum_valid;
    logic signed [DATA_W-1:0] psum_data;
    logic                     psum_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_ready;

    modport master (
        output psum_valid, psum_data, out_ready,
        input  psum_ready, out_valid, out_data
    );

    modport slave (
        input  psum_valid, psum_data, out_ready,
        output psum_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates npass rows of partial sums into a row buffer, then drains the row
// through a saturating / optional-ReLU registered output stage.
module psum_accumulator #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [6:0]          cfg_row_len,
    input  logic [4:0]          cfg_npass,
    input  logic                cfg_relu,
    psum_accumulator_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [6:0]                row_len_q, row_len_d;
    logic [6:0]                idx_q, idx_d;
    logic [4:0]                npass_q, npass_d;
    logic [4:0]                pass_cnt_q, pass_cnt_d;
    logic                      relu_q, relu_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic signed [ACC_W-1:0]   row_buf [MAX_LEN];
    logic                      wr_en;
    logic signed [ACC_W-1:0]   wr_data;
    logic signed [ACC_W-1:0]   rd_data;
    logic signed [ACC_W-1:0]   psum_ext;
    logic                      cfg_bad;
    logic                      xfer;
    logic                      last_idx;
    logic                      accept;

    function automatic logic signed [DATA_W-1:0] sat_word(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-DATA_W:0] hi;
        hi = a[ACC_W-1:DATA_W-1];
        // Value fits when every bit above the target sign bit equals it.
        if ((&hi) || !(|hi))
            return a[DATA_W-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_word(input logic signed [DATA_W-1:0] w,
                                                            input logic en);
        return (en && w[DATA_W-1]) ? '0 : w;
    endfunction

    always_comb begin
        psum_ext = {{(ACC_W-DATA_W){bus.psum_data[DATA_W-1]}}, bus.psum_data};
        rd_data  = row_buf[idx_q[AW-1:0]];
        cfg_bad  = (cfg_row_len == 7'd0) || (cfg_row_len > MAX_LEN_W) || (cfg_npass == 5'd0);
        xfer     = (state_q == ACCUM) && bus.psum_valid;
        last_idx = (idx_q == row_len_q - 7'd1);
        accept   = out_valid_q && bus.out_ready;

        state_d     = state_q;
        row_len_d   = row_len_q;
        npass_d     = npass_q;
        relu_d      = relu_q;
        idx_d       = idx_q;
        pass_cnt_d  = pass_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = psum_ext;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        row_len_d  = cfg_row_len;
                        npass_d    = cfg_npass;
                        relu_d     = cfg_relu;
                        idx_d      = 7'd0;
                        pass_cnt_d = 5'd0;
                        state_d    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (pass_cnt_q != 5'd0)
                        wr_data = rd_data + psum_ext;
                    if (last_idx) begin
                        idx_d      = 7'd0;
                        pass_cnt_d = pass_cnt_q + 5'd1;
                        if (pass_cnt_q == npass_q - 5'd1)
                            state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            DRAIN: begin
                // idx_q counts words already loaded into the output register.
                if (accept && (idx_q == row_len_q)) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else if ((accept || !out_valid_q) && (idx_q != row_len_q)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = relu_word(sat_word(rd_data), relu_q);
                    idx_d       = idx_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            row_len_q   <= 7'd0;
            npass_q     <= 5'd0;
            relu_q      <= 1'b0;
            idx_q       <= 7'd0;
            pass_cnt_q  <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_len_q   <= row_len_d;
            npass_q     <= npass_d;
            relu_q      <= relu_d;
            idx_q       <= idx_d;
            pass_cnt_q  <= pass_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Row buffer carries no reset; pass 0 of every row overwrites each entry before it is read.
    always_ff @(posedge clk) begin
        if (wr_en)
            row_buf[idx_q[AW-1:0]] <= wr_data;
    end

    assign bus.psum_ready = (state_q == ACCUM);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter: DATA_W, default 16, psum/ofmap word width, signed two's complement.
REQ-002 Parameter: ACC_W, default 24, internal accumulator width, signed.
REQ-003 Parameter: MAX_LEN, default 64, row-buffer depth in words.
REQ-004 The ports SHALL be:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins one output row; sampled only in IDLE.
- cfg_row_len  in  7  ofmap words per row (ifm_width - filter_width + 1), legal 1..MAX_LEN.
- cfg_npass  in  5  partial-sum passes to accumulate (icb), legal 1..16.
- cfg_relu  in  1  1 = clamp negative results to 0.
- psum_valid  in  1  PE-array top-row psum word valid.
- psum_data  in  DATA_W  psum word.
- psum_ready  out  1  accumulator accepts psum word.
- out_valid  out  1  ofmap word valid.
- out_data  out  DATA_W  ofmap word.
- out_ready  in  1  downstream accepts ofmap word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last ofmap word of the row is accepted.
- err  out  1  one-cycle pulse on illegal configuration at start.

Function
REQ-005 FSM states SHALL be IDLE, ACCUM, DRAIN.
REQ-006 In IDLE, start with legal cfg SHALL latch cfg_row_len, cfg_npass, cfg_relu, clear idx and pass_cnt, and enter ACCUM next cycle; cfg inputs are ignored after latching.
REQ-007 In IDLE, start with cfg_row_len = 0, cfg_row_len > MAX_LEN, or cfg_npass = 0 SHALL pulse err for one cycle and remain in IDLE.
REQ-008 start outside IDLE SHALL be ignored (no err, no restart).
REQ-009 psum_ready SHALL be 1 exactly in ACCUM; a transfer occurs on a cycle with psum_valid & psum_ready.
REQ-010 On a transfer in pass 0, buf[idx] SHALL be written with sign-extended psum_data; in passes 1..npass-1, buf[idx] SHALL become buf[idx] + sign-extended psum_data at ACC_W (no overflow is possible within the legal range).
REQ-011 idx SHALL increment per transfer; at idx = row_len-1 it SHALL wrap to 0 and pass_cnt SHALL increment.
REQ-012 The transfer at idx = row_len-1 in pass npass-1 SHALL move the FSM to DRAIN next cycle; psum_ready SHALL be 0 from that cycle on.
REQ-013 In DRAIN, out_data SHALL be buf[k] saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then forced to 0 if cfg_relu and negative, for k = 0..row_len-1 in order.
REQ-014 The output stage SHALL be registered: out_valid SHALL rise exactly one cycle after entry to DRAIN (two cycles after the final psum transfer).
REQ-015 While out_valid & !out_ready, out_valid and out_data SHALL hold stable; the next word SHALL be presented on the cycle after each accepted word, giving one word per cycle when out_ready is held high.
REQ-016 On acceptance of word row_len-1, out_valid SHALL drop next cycle, done SHALL pulse for that cycle, and the FSM SHALL return to IDLE in that same cycle.
REQ-017 A start arriving on the done cycle SHALL be honoured (IDLE is already active).
REQ-018 psum_valid outside ACCUM SHALL be ignored and SHALL cause no buffer write.

Reset
REQ-019 rstn low SHALL immediately force IDLE, idx = 0, pass_cnt = 0, psum_ready = 0, out_valid = 0, out_data = 0, busy = 0, done = 0, err = 0, regardless of the operation in progress.
REQ-020 Buffer contents after reset are undefined; every row SHALL rewrite them in pass 0 before any read.

Verification
REQ-021 row_len=4, npass=1, psums 1,2,3,4, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles, first out_valid 2 cycles after the last psum, done the cycle after the 4th.
REQ-022 row_len=3, npass=3, each pass 100,-50,7 -> outputs 300,-150,21; with cfg_relu=1 -> 300,0,21.
REQ-023 row_len=2, npass=2, psums 30000 x4 -> both outputs 32767; psums -30000 x4 -> both outputs -32768.
REQ-024 Randomised psum_valid gaps plus out_ready toggling at 50% -> outputs match the model with out_data stable during each stall and no word lost or duplicated.
REQ-025 start with cfg_npass=0 -> err pulse, busy stays 0; start during ACCUM -> ignored, result unchanged.
REQ-026 rstn asserted mid-ACCUM (pass 1 of 2) -> all outputs reset immediately; a fresh row afterwards produces correct results with no carry-over.
